// File: rtl/serial_word_tx.sv
// serial_word_tx
//   Transmit end of the bit-serial two's-complement path. Accepts a parallel word
//   over a valid/ready handshake and shifts it out LSB first, one bit per clock.
//   Every frame is preceded by a one-cycle restart strobe for the downstream
//   serial complementer. The frame is optionally sign-extended by EXT_BITS copies
//   of the word MSB so the negated result has headroom.
//
// Ports
//   t_clk       system clock, rising edge
//   r           synchronous active-high reset
//   load_data   word to transmit (WIDTH bits)
//   load_valid  load_data valid
//   load_ready  block can accept a word (IDLE only)
//   ser_bit     serial data, LSB first
//   ser_valid   ser_bit carries a frame bit this cycle
//   ser_rst     frame-restart strobe to downstream complementer
//   done        one-cycle pulse coincident with the last frame bit
module serial_word_tx #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned EXT_BITS = 0
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_rst,
    output logic             done
);

    localparam int unsigned FRAME = WIDTH + EXT_BITS;
    localparam int unsigned CW    = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LastCnt = CW'(FRAME - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StShift
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (load_valid) begin
                    shreg_d = load_data;
                    cnt_d   = '0;
                    state_d = StSync;
                end
            end
            StSync: begin
                state_d = StShift;
            end
            StShift: begin
                // Arithmetic shift: the MSB stays put so extension bits repeat it.
                shreg_d = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
                if (cnt_q == LastCnt) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are pure decodes of registered state; no input reaches an output.
    assign load_ready = (state_q == StIdle);
    assign ser_rst    = (state_q == StSync);
    assign ser_valid  = (state_q == StShift);
    assign ser_bit    = (state_q == StShift) && shreg_q[0];
    assign done       = (state_q == StShift) && (cnt_q == LastCnt);

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx
//   Directed bench for serial_word_tx. dut_a is WIDTH=8/EXT_BITS=0, dut_b is
//   WIDTH=8/EXT_BITS=2. Inputs change 1 ns after a rising edge; outputs are
//   checked at that same point, well away from the next edge.
module tb_serial_word_tx;

    logic       t_clk;
    logic       r;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, bit_a, sval_a, srst_a, done_a;
    logic       ready_b, bit_b, sval_b, srst_b, done_b;

    int checks;
    int passed;

    serial_word_tx #(.WIDTH(8), .EXT_BITS(0)) dut_a (
        .t_clk     (t_clk),
        .r         (r),
        .load_data (data_a),
        .load_valid(valid_a),
        .load_ready(ready_a),
        .ser_bit   (bit_a),
        .ser_valid (sval_a),
        .ser_rst   (srst_a),
        .done      (done_a)
    );

    serial_word_tx #(.WIDTH(8), .EXT_BITS(2)) dut_b (
        .t_clk     (t_clk),
        .r         (r),
        .load_data (data_b),
        .load_valid(valid_b),
        .load_ready(ready_b),
        .ser_bit   (bit_b),
        .ser_valid (sval_b),
        .ser_rst   (srst_b),
        .done      (done_b)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    task automatic step();
        @(posedge t_clk);
        #1;
    endtask

    task automatic test_reset();
        r = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a = 8'h00;
        data_b = 8'h00;
        step();
        step();
        checks++;
        if ({ready_a, bit_a, sval_a, srst_a, done_a} !== 5'b10000)
            $display("FAIL reset_a: got %b want 10000", {ready_a, bit_a, sval_a, srst_a, done_a});
        else passed++;
        checks++;
        if ({ready_b, bit_b, sval_b, srst_b, done_b} !== 5'b10000)
            $display("FAIL reset_b: got %b want 10000", {ready_b, bit_b, sval_b, srst_b, done_b});
        else passed++;
        r = 1'b0;
        step();
        checks++;
        if ({ready_a, sval_a, srst_a} !== 3'b100)
            $display("FAIL idle_after_reset: got %b want 100", {ready_a, sval_a, srst_a});
        else passed++;
    endtask

    // 8'hB4 on dut_a; also run the stream through a serial complementer model.
    task automatic test_basic_frame();
        logic [7:0] word;
        logic [7:0] neg;
        logic       seen;
        word = 8'hB4;
        seen = 1'b0;
        neg = '0;
        data_a = word;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        checks++;
        if ({ready_a, bit_a, sval_a, srst_a, done_a} !== 5'b00010)
            $display("FAIL basic_sync: got %b want 00010", {ready_a, bit_a, sval_a, srst_a, done_a});
        else passed++;
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({bit_a, sval_a, srst_a, done_a, ready_a} !== {word[k], 1'b1, 1'b0, (k == 7), 1'b0})
                $display("FAIL basic_bit%0d: got %b want %b", k,
                         {bit_a, sval_a, srst_a, done_a, ready_a},
                         {word[k], 1'b1, 1'b0, (k == 7), 1'b0});
            else passed++;
            neg[k] = seen ? ~bit_a : bit_a;
            seen = seen | bit_a;
            step();
        end
        checks++;
        if (neg !== 8'h4C) $display("FAIL basic_negated: got %h want 4c", neg);
        else passed++;
        checks++;
        if ({ready_a, sval_a, done_a} !== 3'b100)
            $display("FAIL basic_back_idle: got %b want 100", {ready_a, sval_a, done_a});
        else passed++;
    endtask

    // 8'h80 on dut_b (EXT_BITS=2): 10-bit frame, MSB repeated twice.
    task automatic test_sign_ext();
        logic [9:0] raw;
        logic [9:0] neg;
        logic       seen;
        logic       exp_bit;
        seen = 1'b0;
        raw = '0;
        neg = '0;
        data_b = 8'h80;
        valid_b = 1'b1;
        step();
        valid_b = 1'b0;
        data_b = 8'h00;
        checks++;
        if ({srst_b, sval_b, ready_b} !== 3'b100)
            $display("FAIL ext_sync: got %b want 100", {srst_b, sval_b, ready_b});
        else passed++;
        step();
        for (int k = 0; k < 10; k++) begin
            exp_bit = (k >= 7);
            checks++;
            if ({bit_b, sval_b, done_b} !== {exp_bit, 1'b1, (k == 9)})
                $display("FAIL ext_bit%0d: got %b want %b", k, {bit_b, sval_b, done_b},
                         {exp_bit, 1'b1, (k == 9)});
            else passed++;
            raw[k] = bit_b;
            neg[k] = seen ? ~bit_b : bit_b;
            seen = seen | bit_b;
            step();
        end
        checks++;
        if (raw !== 10'b1110000000) $display("FAIL ext_raw: got %b want 1110000000", raw);
        else passed++;
        checks++;
        if (neg !== 10'd128) $display("FAIL ext_negated: got %0d want 128", neg);
        else passed++;
        checks++;
        if ({ready_b, sval_b} !== 2'b10) $display("FAIL ext_back_idle: got %b want 10", {ready_b, sval_b});
        else passed++;
    endtask

    // load_valid held high: 8'h01 then 8'hFF, separated by exactly IDLE + SYNC.
    task automatic test_back_to_back();
        logic [7:0] w0;
        logic [7:0] w1;
        w0 = 8'h01;
        w1 = 8'hFF;
        data_a = w0;
        valid_a = 1'b1;
        step();
        data_a = w1;   // must not disturb the frame already captured
        checks++;
        if ({srst_a, ready_a} !== 2'b10) $display("FAIL b2b_sync0: got %b want 10", {srst_a, ready_a});
        else passed++;
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({bit_a, sval_a, done_a} !== {w0[k], 1'b1, (k == 7)})
                $display("FAIL b2b_w0_bit%0d: got %b want %b", k, {bit_a, sval_a, done_a},
                         {w0[k], 1'b1, (k == 7)});
            else passed++;
            step();
        end
        checks++;
        if ({ready_a, sval_a, srst_a} !== 3'b100)
            $display("FAIL b2b_idle_gap: got %b want 100", {ready_a, sval_a, srst_a});
        else passed++;
        step();
        checks++;
        if ({srst_a, sval_a, ready_a} !== 3'b100)
            $display("FAIL b2b_sync1: got %b want 100", {srst_a, sval_a, ready_a});
        else passed++;
        valid_a = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({bit_a, sval_a, done_a} !== {w1[k], 1'b1, (k == 7)})
                $display("FAIL b2b_w1_bit%0d: got %b want %b", k, {bit_a, sval_a, done_a},
                         {w1[k], 1'b1, (k == 7)});
            else passed++;
            step();
        end
    endtask

    // Reset during the 4th bit of 8'hA5 drops the frame; then 8'h3C goes out intact.
    task automatic test_mid_reset();
        logic [7:0] w0;
        logic [7:0] w1;
        w0 = 8'hA5;
        w1 = 8'h3C;
        data_a = w0;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bit_a, sval_a} !== {w0[k], 1'b1})
                $display("FAIL mr_bit%0d: got %b want %b", k, {bit_a, sval_a}, {w0[k], 1'b1});
            else passed++;
            step();
        end
        // Load request in the same cycle as reset must be ignored.
        r = 1'b1;
        valid_a = 1'b1;
        data_a = 8'h55;
        step();
        r = 1'b0;
        valid_a = 1'b0;
        checks++;
        if ({ready_a, bit_a, sval_a, srst_a, done_a} !== 5'b10000)
            $display("FAIL mr_after_reset: got %b want 10000", {ready_a, bit_a, sval_a, srst_a, done_a});
        else passed++;
        step();
        checks++;
        if ({ready_a, srst_a, sval_a} !== 3'b100)
            $display("FAIL mr_no_sync: got %b want 100", {ready_a, srst_a, sval_a});
        else passed++;
        data_a = w1;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        checks++;
        if (srst_a !== 1'b1) $display("FAIL mr_sync: got %b want 1", srst_a);
        else passed++;
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({bit_a, sval_a, done_a} !== {w1[k], 1'b1, (k == 7)})
                $display("FAIL mr_w1_bit%0d: got %b want %b", k, {bit_a, sval_a, done_a},
                         {w1[k], 1'b1, (k == 7)});
            else passed++;
            step();
        end
    endtask

    // load_valid and new data during SHIFT are ignored.
    task automatic test_ignore_busy();
        logic [7:0] word;
        word = 8'h5A;
        data_a = word;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                data_a = 8'hFF;
                valid_a = 1'b1;
                #1;
                checks++;
                if (ready_a !== 1'b0) $display("FAIL busy_ready: got %b want 0", ready_a);
                else passed++;
            end
            if (k == 5) valid_a = 1'b0;
            checks++;
            if ({bit_a, sval_a, done_a} !== {word[k], 1'b1, (k == 7)})
                $display("FAIL busy_bit%0d: got %b want %b", k, {bit_a, sval_a, done_a},
                         {word[k], 1'b1, (k == 7)});
            else passed++;
            step();
        end
        checks++;
        if ({ready_a, srst_a, sval_a} !== 3'b100)
            $display("FAIL busy_end_idle: got %b want 100", {ready_a, srst_a, sval_a});
        else passed++;
        step();
        checks++;
        if (srst_a !== 1'b0) $display("FAIL busy_no_extra_frame: got %b want 0", srst_a);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_basic_frame();
        test_sign_ext();
        test_back_to_back();
        test_mid_reset();
        test_ignore_busy();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
